// File: rtl/traffic_light_sequencer_if.sv
// Signal bundle between the traffic light sequencer and its environment.
// The master drives timing, demand and flash mode; the slave (the sequencer) returns the light state.
interface traffic_light_sequencer_if #(
  parameter int unsigned N_PHASES = 4
);
  localparam int unsigned PH_W = (N_PHASES > 2) ? $clog2(N_PHASES) : 1;

  logic                    tick;
  logic [N_PHASES-1:0]     veh_req;
  logic                    flash_mode;
  logic [2*N_PHASES-1:0]   lights;
  logic [PH_W-1:0]         active_phase;
  logic [1:0]              ctrl_state;

  modport master (
    output tick, veh_req, flash_mode,
    input  lights, active_phase, ctrl_state
  );

  modport slave (
    input  tick, veh_req, flash_mode,
    output lights, active_phase, ctrl_state
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Demand-actuated multi-phase traffic light controller with timed yellow / all-red clearance,
// latched per-phase requests, resting green and a flash mode for night/fault operation.
module traffic_light_sequencer #(
  parameter int unsigned N_PHASES     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned FLASH_TICKS  = 8
) (
  input  logic clk,
  input  logic reset_n,
  traffic_light_sequencer_if.slave bus
);
  localparam int unsigned PH_W = (N_PHASES > 2) ? $clog2(N_PHASES) : 1;
  localparam int unsigned LW   = 2 * N_PHASES;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_TICKS - 1);

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;
  localparam logic [1:0] LT_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_FLASH  = 2'b11
  } state_t;

  state_t                state_q,    state_d;
  logic [PH_W-1:0]       active_q,   active_d;
  logic [PH_W-1:0]       next_q,     next_d;
  logic [CNT_W-1:0]      timer_q,    timer_d;
  logic [N_PHASES-1:0]   pending_q,  pending_d;
  logic                  flash_ph_q, flash_ph_d;
  logic [LW-1:0]         lights_q,   lights_d;

  // Per-phase light codes for a given controller state.
  function automatic logic [LW-1:0] decode(state_t st, logic [PH_W-1:0] ph, logic fph);
    logic [LW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      case (st)
        ST_GREEN:  v[2*i +: 2] = (PH_W'(i) == ph) ? LT_GREEN  : LT_RED;
        ST_YELLOW: v[2*i +: 2] = (PH_W'(i) == ph) ? LT_YELLOW : LT_RED;
        ST_ALLRED: v[2*i +: 2] = LT_RED;
        default:   v[2*i +: 2] = fph ? LT_OFF : LT_YELLOW;
      endcase
    end
    return v;
  endfunction

  // First pending phase after the active one, wrapping round; the active phase itself is never chosen.
  function automatic logic [PH_W-1:0] next_from(logic [PH_W-1:0] cur, logic [N_PHASES-1:0] pend);
    logic [PH_W-1:0] sel;
    logic [PH_W-1:0] idx;
    logic            found;
    sel   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k < N_PHASES; k++) begin
      idx = PH_W'((32'(cur) + k) % N_PHASES);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  // Next-state, timer, demand latching and output decode.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    next_d     = next_q;
    timer_d    = timer_q;
    flash_ph_d = flash_ph_q;
    pending_d  = pending_q | bus.veh_req;

    if (state_q == ST_GREEN) begin
      pending_d[active_q] = 1'b0;
    end

    if (bus.flash_mode && (state_q != ST_FLASH)) begin
      state_d    = ST_FLASH;
      flash_ph_d = 1'b0;
      timer_d    = FLASH_LD;
    end else if (state_q == ST_FLASH) begin
      if (!bus.flash_mode) begin
        state_d = ST_ALLRED;
        next_d  = '0;
        timer_d = ALLRED_LD;
      end else if (bus.tick) begin
        if (timer_q == '0) begin
          flash_ph_d = ~flash_ph_q;
          timer_d    = FLASH_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
    end else if (bus.tick) begin
      if (timer_q != '0) begin
        timer_d = timer_q - CNT_W'(1);
      end else begin
        case (state_q)
          ST_GREEN: begin
            // Rest in green with the timer parked at zero until some other phase has demand.
            if (pending_q != '0) begin
              next_d  = next_from(active_q, pending_q);
              state_d = ST_YELLOW;
              timer_d = YELLOW_LD;
            end
          end
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            timer_d = ALLRED_LD;
          end
          ST_ALLRED: begin
            state_d  = ST_GREEN;
            active_d = next_q;
            timer_d  = GREEN_LD;
          end
          default: ;
        endcase
      end
    end

    if ((state_d == ST_GREEN) && (state_q != ST_GREEN)) begin
      pending_d[active_d] = 1'b0;
    end

    lights_d = decode(state_d, active_d, flash_ph_d);
  end

  // State register; lights are registered alongside so they track the state with no extra delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_GREEN;
      active_q   <= '0;
      next_q     <= '0;
      timer_q    <= GREEN_LD;
      pending_q  <= '0;
      flash_ph_q <= 1'b0;
      lights_q   <= decode(ST_GREEN, '0, 1'b0);
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      next_q     <= next_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      flash_ph_q <= flash_ph_d;
      lights_q   <= lights_d;
    end
  end

  assign bus.lights       = lights_q;
  assign bus.active_phase = active_q;
  assign bus.ctrl_state   = state_q;
endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Randomised scoreboard bench for traffic_light_sequencer against a phase/interval reference model.
module tb_traffic_light_sequencer;
  localparam int unsigned NP = 4;
  localparam int unsigned PW = 2;
  localparam int GT = 3, YT = 2, AT = 1, FT = 2;
  localparam int M_GREEN = 0, M_YELLOW = 1, M_ALLRED = 2, M_FLASH = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  traffic_light_sequencer_if #(.N_PHASES(NP)) bus ();

  traffic_light_sequencer #(
    .N_PHASES(NP), .CNT_W(8), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT), .FLASH_TICKS(FT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [2*NP-1:0] lights;
    logic [PW-1:0]   ph;
    logic [1:0]      st;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: current interval kind, owning phase, ticks consumed, demand set.
  int m_mode, m_phase, m_elapsed, m_next, m_fph;
  bit m_pend[NP];

  function automatic int dur(int mode);
    case (mode)
      M_GREEN:  return GT;
      M_YELLOW: return YT;
      M_ALLRED: return AT;
      default:  return FT;
    endcase
  endfunction

  function automatic logic [2*NP-1:0] model_lights();
    logic [2*NP-1:0] v;
    logic [1:0] c;
    v = '0;
    for (int i = 0; i < NP; i++) begin
      case (m_mode)
        M_GREEN:  c = (i == m_phase) ? 2'b00 : 2'b10;
        M_YELLOW: c = (i == m_phase) ? 2'b01 : 2'b10;
        M_ALLRED: c = 2'b10;
        default:  c = (m_fph != 0) ? 2'b11 : 2'b01;
      endcase
      v[2*i +: 2] = c;
    end
    return v;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.lights = model_lights();
    e.ph     = PW'(m_phase);
    e.st     = 2'(m_mode);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_GREEN; m_phase = 0; m_elapsed = 0; m_next = 0; m_fph = 0;
    for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input bit tk, input logic [NP-1:0] req, input bit fl);
    bit old_pend[NP];
    bit any;
    any = 1'b0;
    for (int i = 0; i < NP; i++) begin
      old_pend[i] = m_pend[i];
      any |= m_pend[i];
      if (req[i] && !(m_mode == M_GREEN && i == m_phase)) m_pend[i] = 1'b1;
    end
    if (fl && m_mode != M_FLASH) begin
      m_mode = M_FLASH; m_fph = 0; m_elapsed = 0;
    end else if (m_mode == M_FLASH && !fl) begin
      m_mode = M_ALLRED; m_next = 0; m_elapsed = 0;
    end else if (tk) begin
      if (m_elapsed < dur(m_mode) - 1) begin
        m_elapsed++;
      end else begin
        case (m_mode)
          M_FLASH: begin m_fph ^= 1; m_elapsed = 0; end
          M_GREEN: if (any) begin
            for (int k = 1; k < NP; k++) begin
              if (old_pend[(m_phase + k) % NP]) begin
                m_next = (m_phase + k) % NP;
                break;
              end
            end
            m_mode = M_YELLOW; m_elapsed = 0;
          end
          M_YELLOW: begin m_mode = M_ALLRED; m_elapsed = 0; end
          default: begin
            m_mode = M_GREEN; m_phase = m_next; m_elapsed = 0;
            m_pend[m_phase] = 1'b0;
          end
        endcase
      end
    end
  endtask

  task automatic compare(input string name, input exp_t got, input exp_t exp);
    n_vec++;
    if ({got.lights, got.ph, got.st} !== {exp.lights, exp.ph, exp.st}) begin
      n_err++;
      $display("FAIL %s @%0t: got lights=%b phase=%0d state=%b, expected lights=%b phase=%0d state=%b",
               name, $time, got.lights, got.ph, got.st, exp.lights, exp.ph, exp.st);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t g;
    g.lights = bus.lights;
    g.ph     = bus.active_phase;
    g.st     = bus.ctrl_state;
    return g;
  endfunction

  // Apply one cycle of stimulus (already at the negative edge) and queue its expected result.
  task automatic apply(input bit tk, input logic [NP-1:0] req, input bit fl);
    bus.tick = tk; bus.veh_req = req; bus.flash_mode = fl;
    model_step(tk, req, fl);
    sb_q.push_back(model_out());
  endtask

  task automatic drive(input bit tk, input logic [NP-1:0] req, input bit fl);
    @(negedge clk);
    apply(tk, req, fl);
  endtask

  // Monitor: every cycle after the edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare("cycle", dut_out(), e);
      end
    end
  end

  initial begin
    bit fl;
    bit tk;
    bit did_reset;
    logic [NP-1:0] req;
    bus.tick = 1'b0; bus.veh_req = '0; bus.flash_mode = 1'b0;
    model_reset();
    #12;
    compare("reset_state", dut_out(), model_out());
    @(negedge clk);
    reset_n = 1'b1;

    repeat (20) drive(1'b1, '0, 1'b0);
    drive(1'b1, NP'(4'b0010), 1'b0);
    repeat (10) drive(1'b1, '0, 1'b0);
    drive(1'b1, NP'(4'b1010), 1'b0);
    repeat (3) drive(1'b1, NP'(4'b0001), 1'b0);
    repeat (4) drive(1'b1, '0, 1'b0);
    repeat (7) drive(1'b1, '0, 1'b1);
    repeat (8) drive(1'b1, '0, 1'b0);

    fl = 1'b0;
    did_reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tk = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) req[i] = ($urandom_range(0, 7) == 0);
      if (fl ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 79) == 0)) fl = ~fl;
      if (!did_reset && c > 1000 && (m_mode == M_ALLRED || c == 2500)) begin
        did_reset = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare("async_reset", dut_out(), model_out());
        @(negedge clk);
        reset_n = 1'b1;
        apply(tk, req, fl);
      end else begin
        drive(tk, req, fl);
      end
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
